// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake.
// Optional feature macro MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle multiplier instead of shift-add.
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
   localparam logic [WIDTH-1:0]   ZERO_W   = WIDTH'(0);
   localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
   localparam logic [WIDTH-1:0]   ONES_W   = ~ZERO_W;
   localparam logic [WIDTH:0]     ZERO_W1  = (WIDTH+1)'(0);
   localparam logic [2*WIDTH-1:0] ZERO_2W  = (2*WIDTH)'(0);
   localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t state_r, state_next_s;

   logic [2*WIDTH-1:0] acc_r, acc_next_s, prod_s, prod_fix_s;
   logic [WIDTH-1:0]   opnd_r, a_mag_s, b_mag_s, quo_fix_s, rem_fix_s, res_hi_s, res_lo_s;
   logic [WIDTH:0]     mul_sum_s, rem_sh_s, rem_diff_s;
   logic [CW-1:0]      cnt_r;
   logic               is_mul_r, neg_r, rneg_r, divz_r;
   logic               op_mul_s, op_div_s, op_sgn_s, op_mthi_s, op_mtlo_s, accept_s;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
      magnitude = neg ? (~v + ONE_W) : v;
   endfunction

   // Opcode decode.
   always_comb begin
      op_mul_s  = 1'b0;
      op_div_s  = 1'b0;
      op_sgn_s  = 1'b0;
      op_mthi_s = 1'b0;
      op_mtlo_s = 1'b0;
      case (op)
         3'b000:  begin op_mul_s = 1'b1; op_sgn_s = 1'b1; end
         3'b001:  op_mul_s = 1'b1;
         3'b010:  begin op_div_s = 1'b1; op_sgn_s = 1'b1; end
         3'b011:  op_div_s = 1'b1;
         3'b100:  op_mthi_s = 1'b1;
         3'b101:  op_mtlo_s = 1'b1;
         default: op_mul_s = 1'b0;
      endcase
   end

   assign accept_s = start && !flush && (state_r == ST_IDLE) &&
                     (op_mul_s || op_div_s || op_mthi_s || op_mtlo_s);
   assign a_mag_s  = magnitude(a, op_sgn_s & a[WIDTH-1]);
   assign b_mag_s  = magnitude(b, op_sgn_s & b[WIDTH-1]);

   // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : ZERO_W1);
      rem_sh_s   = acc_r[2*WIDTH-1:WIDTH-1];
      rem_diff_s = rem_sh_s - {1'b0, opnd_r};
      if (is_mul_r) begin
         acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end else if (!rem_diff_s[WIDTH]) begin
         acc_next_s = {rem_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
         acc_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
   end

   // Sign correction of the unsigned magnitude result; b==0 forces an all-ones quotient.
   always_comb begin
`ifdef MDU_FAST_MUL_EN
      prod_s = {ZERO_W, opnd_r} * {ZERO_W, acc_r[WIDTH-1:0]};
`else
      prod_s = acc_r;
`endif
      prod_fix_s = neg_r ? (~prod_s + ONE_2W) : prod_s;
      quo_fix_s  = divz_r ? ONES_W : magnitude(acc_r[WIDTH-1:0], neg_r);
      rem_fix_s  = magnitude(acc_r[2*WIDTH-1:WIDTH], rneg_r);
      if (is_mul_r) begin
         res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
         res_lo_s = prod_fix_s[WIDTH-1:0];
      end else begin
         res_hi_s = rem_fix_s;
         res_lo_s = quo_fix_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && (op_mul_s || op_div_s)) begin
`ifdef MDU_FAST_MUL_EN
               state_next_s = op_mul_s ? ST_FIX : ST_RUN;
`else
               state_next_s = ST_RUN;
`endif
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (flush) begin
               state_next_s = ST_IDLE;
            end else if (cnt_r == CNT_ONE) begin
               state_next_s = ST_FIX;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_FIX:  state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Operand latch, iteration datapath and HI/LO/handshake outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         div0     <= 1'b0;
         hi       <= ZERO_W;
         lo       <= ZERO_W;
         acc_r    <= ZERO_2W;
         opnd_r   <= ZERO_W;
         cnt_r    <= CNT_ZERO;
         is_mul_r <= 1'b0;
         neg_r    <= 1'b0;
         rneg_r   <= 1'b0;
         divz_r   <= 1'b0;
      end else begin
         busy <= (state_next_s != ST_IDLE);
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  div0 <= 1'b0;
                  if (op_mthi_s) begin
                     hi <= a;
                  end else if (op_mtlo_s) begin
                     lo <= a;
                  end else begin
                     // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                     opnd_r   <= op_mul_s ? a_mag_s : b_mag_s;
                     acc_r    <= {ZERO_W, (op_mul_s ? b_mag_s : a_mag_s)};
                     cnt_r    <= CNT_INIT;
                     is_mul_r <= op_mul_s;
                     neg_r    <= op_sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                     rneg_r   <= op_sgn_s & a[WIDTH-1];
                     divz_r   <= op_div_s && (b == ZERO_W);
                  end
               end
            end
            ST_RUN: begin
               if (!flush) begin
                  acc_r <= acc_next_s;
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_FIX: begin
               if (!flush) begin
                  hi   <= res_hi_s;
                  lo   <= res_lo_s;
                  done <= 1'b1;
                  div0 <= divz_r;
               end
            end
            default: done <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: cycle-level behavioural model plus hand-computed literal checks.
module tb_mdu_iter;
   localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif

   logic          clk = 1'b0;
   logic          resetn, start, flush;
   logic [2:0]    op;
   logic [W-1:0]  a, b;
   logic          busy, done, div0;
   logic [W-1:0]  hi, lo;

   int vecs = 0;
   int errs = 0;
   bit chk_en = 1'b0;

   // model state
   bit            m_busy, m_done, m_div0, p_z;
   int            m_left;
   logic [W-1:0]  m_hi, m_lo, p_hi, p_lo;

   mdu_iter #(.WIDTH(W)) dut (
      .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural result of an operation computed with plain integer arithmetic.
   task automatic model_result(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output logic [W-1:0] rh, output logic [W-1:0] rl, output bit rz);
      longint sx, sy, p;
      logic [63:0] up;
      rz = 1'b0;
      rh = '0;
      rl = '0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         3'b000: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
         3'b001: begin up = {32'd0, x} * {32'd0, y}; rh = up[63:32]; rl = up[31:0]; end
         3'b010, 3'b011: begin
            if (y == 32'd0) begin
               rl = 32'hFFFF_FFFF; rh = x; rz = 1'b1;
            end else if (o == 3'b010) begin
               p = sx / sy; rl = p[31:0];
               p = sx % sy; rh = p[31:0];
            end else begin
               rl = x / y; rh = x % y;
            end
         end
         default: begin rh = '0; rl = '0; end
      endcase
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_done = 1'b0; m_div0 = 1'b0; m_left = 0;
      m_hi = '0; m_lo = '0;
   endtask

   // Advance one clock edge with the current inputs, updating the model for that edge.
   task automatic step();
      bit nb, nd, nz;
      int nl;
      logic [W-1:0] nh, nlo, rh, rl;
      bit rz;
      nb = m_busy; nd = 1'b0; nz = m_div0; nl = m_left; nh = m_hi; nlo = m_lo;
      if (m_busy) begin
         if (flush) begin
            nb = 1'b0;
         end else begin
            nl = m_left - 1;
            if (nl == 0) begin
               nb = 1'b0; nd = 1'b1; nh = p_hi; nlo = p_lo; nz = p_z;
            end
         end
      end else if (start && !flush) begin
         case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
               model_result(op, a, b, rh, rl, rz);
               p_hi = rh; p_lo = rl; p_z = rz;
               nb = 1'b1; nz = 1'b0;
               nl = (op <= 3'b001) ? MUL_LAT : W + 1;
            end
            3'b100: begin nh = a; nz = 1'b0; end
            3'b101: begin nlo = a; nz = 1'b0; end
            default: ;
         endcase
      end
      @(posedge clk);
      if (resetn) begin
         m_busy = nb; m_done = nd; m_div0 = nz; m_left = nl; m_hi = nh; m_lo = nlo;
      end else begin
         model_reset();
      end
      #1;
   endtask

   // Run an operation to completion; returns the number of cycles busy was seen high.
   task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int cyc);
      start = 1'b1; op = o; a = x; b = y;
      step();
      start = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         cyc++;
         step();
      end
   endtask

   // Compare process: every output against the model on each falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(m_done));
         check("div0", 32'(div0), 32'(m_div0));
         check("hi", hi, m_hi);
         check("lo", lo, m_lo);
      end
   end

   initial begin
      int cyc;
      resetn = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
      model_reset();
      p_hi = '0; p_lo = '0; p_z = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      resetn = 1'b1;
      chk_en = 1'b1;

      run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
      check("multu_cycles", 32'(cyc), 32'(MUL_LAT));
      check("multu_done", 32'(done), 32'd1);
      check("multu_hi", hi, 32'hFFFF_FFFE);
      check("multu_lo", lo, 32'h0000_0001);
      step();
      check("multu_done_pulse", 32'(done), 32'd0);

      run(3'b000, 32'hFFFF_FFFD, 32'd7, cyc);
      check("mult_cycles", 32'(cyc), 32'(MUL_LAT));
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFEB);
      run(3'b000, 32'h8000_0000, 32'h8000_0000, cyc);
      check("mult_minmin_hi", hi, 32'h4000_0000);
      check("mult_minmin_lo", lo, 32'h0000_0000);

      run(3'b010, 32'hFFFF_FFF9, 32'd2, cyc);
      check("div_cycles", 32'(cyc), 32'(W + 1));
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      check("div_ovf_lo", lo, 32'h8000_0000);
      check("div_ovf_hi", hi, 32'h0000_0000);
      run(3'b010, 32'd7, 32'hFFFF_FFFE, cyc);
      check("div_negb_lo", lo, 32'hFFFF_FFFD);
      check("div_negb_hi", hi, 32'h0000_0001);
      run(3'b010, 32'hFFFF_FFF9, 32'd0, cyc);
      check("div_z_lo", lo, 32'hFFFF_FFFF);
      check("div_z_hi", hi, 32'hFFFF_FFF9);
      check("div_z_div0", 32'(div0), 32'd1);

      run(3'b011, 32'd100, 32'd0, cyc);
      check("divu_z_cycles", 32'(cyc), 32'(W + 1));
      check("divu_z_lo", lo, 32'hFFFF_FFFF);
      check("divu_z_hi", hi, 32'd100);
      check("divu_z_div0", 32'(div0), 32'd1);
      run(3'b011, 32'd100, 32'd7, cyc);
      check("divu_div0_clr", 32'(div0), 32'd0);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);

      // flush at busy cycle 10
      start = 1'b1; op = 3'b011; a = 32'd50; b = 32'd3;
      step();
      start = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_done", 32'(done), 32'd0);
      check("flush_lo", lo, 32'd14);
      check("flush_hi", hi, 32'd2);

      // start and flush on the same edge
      start = 1'b1; flush = 1'b1; op = 3'b011; a = 32'd9; b = 32'd2;
      step();
      start = 1'b0; flush = 1'b0;
      check("startflush_busy", 32'(busy), 32'd0);
      step();

      // flush on the FIX edge
      start = 1'b1; op = 3'b011; a = 32'd9; b = 32'd2;
      step();
      start = 1'b0;
      repeat (W) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fixflush_done", 32'(done), 32'd0);
      check("fixflush_lo", lo, 32'd14);
      step();

      // start while busy is ignored
      start = 1'b1; op = 3'b011; a = 32'd1000; b = 32'd7;
      step();
      start = 1'b0;
      repeat (3) step();
      start = 1'b1; op = 3'b010; a = 32'd1; b = 32'd1;
      step();
      start = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         cyc++;
         step();
      end
      check("busyign_lo", lo, 32'd142);
      check("busyign_hi", hi, 32'd6);

      // back-to-back MTHI/MTLO, then flush-dropped MTHI and an undefined op
      start = 1'b1; op = 3'b100; a = 32'h1234_5678;
      step();
      op = 3'b101; a = 32'h9ABC_DEF0;
      step();
      check("mthi_hi", hi, 32'h1234_5678);
      check("mtlo_lo", lo, 32'h9ABC_DEF0);
      check("mt_busy", 32'(busy), 32'd0);
      op = 3'b100; a = 32'hDEAD_BEEF; flush = 1'b1;
      step();
      flush = 1'b0; op = 3'b110;
      step();
      start = 1'b0;
      check("mt_flush_hi", hi, 32'h1234_5678);
      check("undef_busy", 32'(busy), 32'd0);

      // reset in the middle of a divide
      start = 1'b1; op = 3'b010; a = 32'd77; b = 32'd5;
      step();
      start = 1'b0;
      repeat (5) step();
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      step();
      resetn = 1'b1;
      run(3'b011, 32'd77, 32'd5, cyc);
      check("post_rst_lo", lo, 32'd15);
      check("post_rst_hi", hi, 32'd2);
      step();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
